// File: rtl/fpu_format_convert.sv
// Pipelined IEEE-754 format converter (any exp/mantissa widths), two register stages:
// S1 classifies and normalises the input, S2 rounds, packs and raises flags.
module fpu_format_convert #(
  parameter int IN_EXP  = 11,
  parameter int IN_MAN  = 52,
  parameter int OUT_EXP = 8,
  parameter int OUT_MAN = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_EXP+IN_MAN:0]   in_data,
  input  logic [2:0]               in_rm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_EXP+OUT_MAN:0] out_data,
  output logic [4:0]               out_flags
);

  localparam int K       = OUT_MAN + 1;
  localparam int MAX_SH  = OUT_MAN + 2;
  localparam int SHW     = $clog2(MAX_SH + 1);
  localparam int XW      = IN_MAN + OUT_MAN + 4;
  localparam int LZW     = $clog2(IN_MAN + 1);
  localparam int W_A     = (IN_EXP > OUT_EXP) ? IN_EXP : OUT_EXP;
  localparam int W_B     = ($clog2(IN_MAN + 2) > $clog2(OUT_MAN + 3)) ? $clog2(IN_MAN + 2)
                                                                      : $clog2(OUT_MAN + 3);
  localparam int EW      = ((W_A > W_B) ? W_A : W_B) + 2;
  localparam int BIAS_D  = ((1 << (OUT_EXP - 1)) - 1) - ((1 << (IN_EXP - 1)) - 1);
  localparam int EXP_MAX = (1 << OUT_EXP) - 1;

  typedef struct packed {
    logic            sign;
    logic            zero;
    logic            inf;
    logic            nan;
    logic            snan;
    logic            tiny;
    logic [2:0]      rm;
    logic [SHW-1:0]  shift;
    logic [EW-1:0]   bexp;
    logic [IN_MAN:0] sig;
  } s1_t;

  logic                 in_sign;
  logic [IN_EXP-1:0]    in_exp;
  logic [IN_MAN-1:0]    in_man;
  logic [LZW-1:0]       lz;
  logic [EW-1:0]        sh_full;
  s1_t                  dec;
  s1_t                  s1_d, s1_q;
  logic                 s1_valid_d, s1_valid_q;
  logic                 s2_valid_d, s2_valid_q;
  logic [OUT_EXP+OUT_MAN:0] out_data_d, out_data_q;
  logic [4:0]           out_flags_d, out_flags_q;
  logic                 s1_en, s2_en;

  logic [XW-1:0]        ext, shifted;
  logic [K-1:0]         kept;
  logic                 guard, sticky, inexact, inc, ovf, to_inf;
  logic [K:0]           rounded;
  logic [EW-1:0]        exp_r;
  logic [OUT_MAN-1:0]   qnan_man;
  logic [OUT_EXP+OUT_MAN:0] res_data;
  logic [4:0]           res_flags;

  assign {in_sign, in_exp, in_man} = in_data;

  // Biased exponents are kept in EW-bit two's complement; bit EW-1 is the sign.
  always_comb begin : s1_decode
    lz = '0;
    for (int i = 0; i < IN_MAN; i++) begin
      if (in_man[i]) lz = LZW'(IN_MAN - 1 - i);
    end
    dec      = '0;
    dec.sign = in_sign;
    dec.rm   = in_rm;
    dec.zero = (in_exp == '0) && (in_man == '0);
    dec.inf  = (&in_exp) && (in_man == '0);
    dec.nan  = (&in_exp) && (in_man != '0);
    dec.snan = dec.nan && !in_man[IN_MAN-1];
    if (in_exp == '0) begin
      dec.sig  = {in_man, 1'b0} << lz;
      dec.bexp = EW'(BIAS_D) - EW'(lz);
    end else begin
      dec.sig  = {1'b1, in_man};
      dec.bexp = EW'(in_exp) + EW'(BIAS_D);
    end
    dec.tiny = dec.bexp[EW-1] || (dec.bexp == '0);
    sh_full  = EW'(1) - dec.bexp;
    if (dec.tiny) dec.shift = (sh_full > EW'(MAX_SH)) ? SHW'(MAX_SH) : SHW'(sh_full);
  end

  // Wide enough that a maximal right shift never drops a bit below the sticky field.
  always_comb begin : s2_round_pack
    ext     = {s1_q.sig, {(XW - IN_MAN - 1){1'b0}}};
    shifted = ext >> s1_q.shift;
    kept    = shifted[XW-1 -: K];
    guard   = shifted[XW-1-K];
    sticky  = |shifted[XW-2-K:0];
    inexact = guard | sticky;
    case (s1_q.rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s1_q.sign & inexact;
      3'd3:    inc = ~s1_q.sign & inexact;
      3'd4:    inc = guard;
      default: inc = guard & (sticky | kept[0]);
    endcase
    case (s1_q.rm)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = s1_q.sign;
      3'd3:    to_inf = ~s1_q.sign;
      default: to_inf = 1'b1;
    endcase
    rounded = {1'b0, kept} + (K+1)'(inc);
    if (s1_q.tiny) exp_r = EW'(rounded[K-1]);
    else           exp_r = s1_q.bexp + EW'(rounded[K]);
    ovf = !s1_q.tiny && (exp_r >= EW'(EXP_MAX));
    qnan_man = '0;
    qnan_man[OUT_MAN-1] = 1'b1;
    res_flags = '0;
    if (s1_q.nan) begin
      res_data     = {1'b0, {OUT_EXP{1'b1}}, qnan_man};
      res_flags[4] = s1_q.snan;
    end else if (s1_q.inf) begin
      res_data = {s1_q.sign, {OUT_EXP{1'b1}}, {OUT_MAN{1'b0}}};
    end else if (s1_q.zero) begin
      res_data = {s1_q.sign, {OUT_EXP{1'b0}}, {OUT_MAN{1'b0}}};
    end else if (ovf) begin
      res_data  = to_inf ? {s1_q.sign, {OUT_EXP{1'b1}}, {OUT_MAN{1'b0}}}
                         : {s1_q.sign, OUT_EXP'(EXP_MAX - 1), {OUT_MAN{1'b1}}};
      res_flags = 5'b00101;
    end else begin
      res_data  = {s1_q.sign, exp_r[OUT_EXP-1:0], rounded[OUT_MAN-1:0]};
      res_flags = {3'b000, s1_q.tiny & inexact, inexact};
    end
  end

  // valid/ready: a beat moves when valid and ready are both high at the clock edge;
  // a stage loads when empty or when the stage after it is moving, so in_ready
  // follows out_ready combinationally and held outputs stay frozen while stalled.
  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  always_comb begin : pipe_next
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    s2_valid_d  = s2_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = dec;
    end
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d  = res_data;
        out_flags_d = res_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fpu_format_convert.sv
// Directed bench for fpu_format_convert: double->float instance plus a float->double
// (widening) instance sharing clock and reset.
module tb_fpu_format_convert;

  typedef struct {
    logic [63:0] d;
    logic [2:0]  rm;
    logic [31:0] e;
    logic [4:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [63:0] e;
    logic [4:0]  f;
  } wvec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data;
  logic [2:0]  in_rm;
  logic [31:0] out_data;
  logic [4:0]  out_flags;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_data;
  logic [2:0]  w_in_rm;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_flags;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_format_convert dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );

  fpu_format_convert #(.IN_EXP(8), .IN_MAN(23), .OUT_EXP(11), .OUT_MAN(52)) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_rm(w_in_rm),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_flags(w_out_flags)
  );

  // ---------------- driver tasks ----------------
  task automatic convert(input logic [63:0] d, input logic [2:0] rm,
                         output logic [31:0] od, output logic [4:0] of, output int lat);
    @(negedge clk);
    in_data   = d;
    in_rm     = rm;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    od = out_data;
    of = out_flags;
  endtask

  task automatic w_convert(input logic [31:0] d,
                           output logic [63:0] od, output logic [4:0] of, output int lat);
    @(negedge clk);
    w_in_data   = d;
    w_in_rm     = 3'd0;
    w_in_valid  = 1'b1;
    w_out_ready = 1'b1;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    od = w_out_data;
    of = w_out_flags;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
    checks++;
    if (out_flags !== 5'h0) begin failures++; $display("FAIL reset_out_flags: got %h want 00", out_flags); end
    checks++;
    if (w_out_valid !== 1'b0) begin failures++; $display("FAIL reset_w_out_valid: got %b want 0", w_out_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] od;
    logic [4:0]  of;
    int          lat;
    convert(64'h3FF0000000000000, 3'd0, od, of, lat);
    checks++;
    if (od !== 32'h3F800000) begin failures++; $display("FAIL basic_data: got %h want 3f800000", od); end
    checks++;
    if (of !== 5'h00) begin failures++; $display("FAIL basic_flags: got %h want 00", of); end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL basic_latency: got %0d want 2", lat); end
  endtask

  task automatic test_rounding();
    vec_t        t[9];
    logic [31:0] od;
    logic [4:0]  of;
    int          lat;
    t[0] = '{64'h3FF0000010000000, 3'd0, 32'h3F800000, 5'h01};
    t[1] = '{64'h3FF0000010000000, 3'd3, 32'h3F800001, 5'h01};
    t[2] = '{64'h3FF0000010000000, 3'd4, 32'h3F800001, 5'h01};
    t[3] = '{64'h3FF0000010000000, 3'd1, 32'h3F800000, 5'h01};
    t[4] = '{64'hBFF0000010000000, 3'd2, 32'hBF800001, 5'h01};
    t[5] = '{64'hBFF0000010000000, 3'd3, 32'hBF800000, 5'h01};
    t[6] = '{64'h3FFFFFFFFFFFFFFF, 3'd0, 32'h40000000, 5'h01};
    t[7] = '{64'h3FF0000030000000, 3'd0, 32'h3F800002, 5'h01};
    t[8] = '{64'h3FF0000010000000, 3'd7, 32'h3F800000, 5'h01};
    for (int i = 0; i < 9; i++) begin
      convert(t[i].d, t[i].rm, od, of, lat);
      checks++;
      if (od !== t[i].e || of !== t[i].f || lat != 2) begin
        failures++;
        $display("FAIL round[%0d]: got data=%h flags=%h lat=%0d want data=%h flags=%h lat=2",
                 i, od, of, lat, t[i].e, t[i].f);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t        t[8];
    logic [31:0] od;
    logic [4:0]  of;
    int          lat;
    t[0] = '{64'h47F0000000000000, 3'd0, 32'h7F800000, 5'h05};
    t[1] = '{64'h47F0000000000000, 3'd1, 32'h7F7FFFFF, 5'h05};
    t[2] = '{64'hC7F0000000000000, 3'd3, 32'hFF7FFFFF, 5'h05};
    t[3] = '{64'hC7F0000000000000, 3'd2, 32'hFF800000, 5'h05};
    t[4] = '{64'h47F0000000000000, 3'd4, 32'h7F800000, 5'h05};
    t[5] = '{64'h47F0000000000000, 3'd2, 32'h7F7FFFFF, 5'h05};
    t[6] = '{64'h47EFFFFFFFFFFFFF, 3'd0, 32'h7F800000, 5'h05};
    t[7] = '{64'h47EFFFFFFFFFFFFF, 3'd1, 32'h7F7FFFFF, 5'h01};
    for (int i = 0; i < 8; i++) begin
      convert(t[i].d, t[i].rm, od, of, lat);
      checks++;
      if (od !== t[i].e || of !== t[i].f || lat != 2) begin
        failures++;
        $display("FAIL overflow[%0d]: got data=%h flags=%h lat=%0d want data=%h flags=%h lat=2",
                 i, od, of, lat, t[i].e, t[i].f);
      end
    end
  endtask

  task automatic test_special();
    vec_t        t[12];
    logic [31:0] od;
    logic [4:0]  of;
    int          lat;
    t[0]  = '{64'h36A0000000000000, 3'd0, 32'h00000001, 5'h00};
    t[1]  = '{64'h3690000000000000, 3'd0, 32'h00000000, 5'h03};
    t[2]  = '{64'h7FF0000000000001, 3'd0, 32'h7FC00000, 5'h10};
    t[3]  = '{64'hFFF8000000000000, 3'd0, 32'h7FC00000, 5'h00};
    t[4]  = '{64'h8000000000000000, 3'd0, 32'h80000000, 5'h00};
    t[5]  = '{64'hFFF0000000000000, 3'd0, 32'hFF800000, 5'h00};
    t[6]  = '{64'h380FFFFFFFFFFFFF, 3'd0, 32'h00800000, 5'h03};
    t[7]  = '{64'h0000000000000001, 3'd3, 32'h00000001, 5'h03};
    t[8]  = '{64'h0000000000000001, 3'd0, 32'h00000000, 5'h03};
    t[9]  = '{64'hC00C000000000000, 3'd0, 32'hC0600000, 5'h00};
    t[10] = '{64'h3810000000000000, 3'd0, 32'h00800000, 5'h00};
    t[11] = '{64'h3800000000000000, 3'd0, 32'h00400000, 5'h00};
    for (int i = 0; i < 12; i++) begin
      convert(t[i].d, t[i].rm, od, of, lat);
      checks++;
      if (od !== t[i].e || of !== t[i].f || lat != 2) begin
        failures++;
        $display("FAIL special[%0d]: got data=%h flags=%h lat=%0d want data=%h flags=%h lat=2",
                 i, od, of, lat, t[i].e, t[i].f);
      end
    end
  endtask

  task automatic test_widening();
    wvec_t       t[6];
    logic [63:0] od;
    logic [4:0]  of;
    int          lat;
    t[0] = '{32'h00000001, 64'h36A0000000000000, 5'h00};
    t[1] = '{32'h7F800000, 64'h7FF0000000000000, 5'h00};
    t[2] = '{32'h3F800000, 64'h3FF0000000000000, 5'h00};
    t[3] = '{32'h7F800001, 64'h7FF8000000000000, 5'h10};
    t[4] = '{32'h80000000, 64'h8000000000000000, 5'h00};
    t[5] = '{32'hC0600000, 64'hC00C000000000000, 5'h00};
    for (int i = 0; i < 6; i++) begin
      w_convert(t[i].d, od, of, lat);
      checks++;
      if (od !== t[i].e || of !== t[i].f || lat != 2) begin
        failures++;
        $display("FAIL widen[%0d]: got data=%h flags=%h lat=%0d want data=%h flags=%h lat=2",
                 i, od, of, lat, t[i].e, t[i].f);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t        t[8];
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    logic        held = 1'b0;
    logic [31:0] held_d;
    logic [4:0]  held_f;
    logic        exp_rdy;
    t[0] = '{64'h3FF0000000000000, 3'd0, 32'h3F800000, 5'h00};
    t[1] = '{64'h3FF0000010000000, 3'd3, 32'h3F800001, 5'h01};
    t[2] = '{64'h47F0000000000000, 3'd1, 32'h7F7FFFFF, 5'h05};
    t[3] = '{64'h7FF0000000000001, 3'd0, 32'h7FC00000, 5'h10};
    t[4] = '{64'hC00C000000000000, 3'd0, 32'hC0600000, 5'h00};
    t[5] = '{64'h3690000000000000, 3'd0, 32'h00000000, 5'h03};
    t[6] = '{64'h36A0000000000000, 3'd0, 32'h00000001, 5'h00};
    t[7] = '{64'hBFF0000010000000, 3'd2, 32'hBF800001, 5'h01};
    exp_q.delete();
    while ((sent < 8 || exp_q.size() != 0) && cyc < 300) begin
      @(negedge clk);
      out_ready = (cyc >= 2 && cyc < 5) ? 1'b0 : ($urandom_range(0, 9) >= 3);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_data  = t[sent].d;
        in_rm    = t[sent].rm;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_flags !== held_f) begin
          failures++;
          $display("FAIL b2b_stall_hold: got valid=%b data=%h flags=%h want valid=1 data=%h flags=%h",
                   out_valid, out_data, out_flags, held_d, held_f);
        end
      end
      exp_rdy = !(exp_q.size() == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL b2b_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_spurious: got data=%h with no beat in flight, want none", out_data);
        end else if (out_ready) begin
          if ({out_flags, out_data} !== exp_q[0]) begin
            failures++;
            $display("FAIL b2b_data[%0d]: got flags=%h data=%h want flags=%h data=%h",
                     got, out_flags, out_data, exp_q[0][36:32], exp_q[0][31:0]);
          end
          void'(exp_q.pop_front());
          got++;
        end
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_f = out_flags;
      if (in_valid && in_ready) begin
        exp_q.push_back({t[sent].f, t[sent].e});
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 8 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: got %0d results (%0d pending) want 8 (0 pending)", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] od;
    logic [4:0]  of;
    int          lat;
    logic        stale = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h4000000000000000;
    in_rm     = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_fill: got out_valid=%b want 1", out_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_clear: got out_valid=%b want 0", out_valid); end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale) begin failures++; $display("FAIL mid_stale_beat: got out_valid=1 after reset want 0"); end
    convert(64'h3FF0000000000000, 3'd0, od, of, lat);
    checks++;
    if (od !== 32'h3F800000 || of !== 5'h00 || lat != 2) begin
      failures++;
      $display("FAIL mid_recover: got data=%h flags=%h lat=%0d want data=3f800000 flags=00 lat=2",
               od, of, lat);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_rm       = '0;
    out_ready   = 1'b1;
    w_in_valid  = 1'b0;
    w_in_data   = '0;
    w_in_rm     = '0;
    w_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_special();
    test_widening();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
